msd_cmd_sequencer: RTL and testbench
====================================

// Module: msd_cmd_sequencer
// PURPOSE
//  Synthesizable DDR5 closed-page command sequencer between the 16-entry request queue and the DIMM command bus.
//  Takes one request {op, addr[35:0]} at a time and issues ACT0/ACT1 -> RD0/RD1 or WR0/WR1 -> PRE with tRCD/tRTP/tCWL/tBURST/tWR spacing.
//  Tracks per-bank tRP across all 32 banks (8 bank groups x 4 banks) so that a re-activation of a bank is stalled.
//  All timing is in controller clock cycles; one cmd_valid cycle = one command slot.
// PARAMETERS
//  T_RP     39  cycles from PRE to next ACT0 on the same bank
//  T_RCD    39  cycles from ACT0 to RD0/WR0
//  T_RTP    18  read-to-precharge; PRE = RD0 + T_RTP + 1
//  T_CWL    38  write CAS latency
//  T_BURST  8   burst length in cycles
//  T_WR     30  write recovery; PRE = WR0 + T_CWL + T_BURST + T_WR + 1
//  CNT_W    8   width of the main delay counter; must hold T_CWL+T_BURST+T_WR+1
// PORTS
//  clk          in   1   controller clock
//  rst_n        in   1   synchronous active-low reset
//  req_valid    in   1   queue head is valid
//  req_ready    out  1   sequencer can accept a request
//  req_op       in   2   0=data read, 1=write, 2=instr fetch (read), 3=illegal
//  req_addr     in   36  row[33:18] col{[17:12],[5:2]} bank[11:10] bg[9:7] ch[6]
//  cmd_valid    out  1   command slot carries a command
//  cmd_code     out  3   0 NOP,1 ACT0,2 ACT1,3 RD0,4 RD1,5 WR0,6 WR1,7 PRE
//  cmd_ch       out  1   channel of the current request
//  cmd_bg       out  3   bank group
//  cmd_bank     out  2   bank
//  cmd_row      out  16  row (meaningful on ACT0/ACT1)
//  cmd_col      out  10  column (meaningful on RD*/WR*)
//  done         out  1   1-cycle pulse: request retired (asserted with PRE)
//  err          out  1   1-cycle pulse: illegal request dropped
// BEHAVIOUR
//  Reset values: req_ready=0 during reset, then 1; cmd_valid=0, cmd_code=0, all cmd_* fields=0; done=0, err=0.
//  Reset also puts the FSM in IDLE and clears all 32 tRP counters (every bank is ready).
//  Handshake: req_ready=1 only in IDLE. Acceptance = req_valid & req_ready at a rising edge; fields are latched at that edge.
//  Illegal request (op==3 or addr[6]==1): accepted, err pulses the next cycle, no commands, FSM stays in IDLE.
//  FSM: IDLE -> CHK -> ACT0 -> ACT1 -> WAIT_RCD -> CAS0 -> CAS1 -> WAIT_PRE -> PRE -> IDLE.
//  CHK: stays while the tRP counter of the target {bg,bank} is nonzero; leaves in the same cycle the counter is 0,
//    so ACT0 appears in the cycle after acceptance if the bank is ready.
//  ACT0 (cycle A) and ACT1 (cycle A+1) are back to back.
//  CAS0 issues in cycle A+T_RCD; read ops give RD0 then RD1; write gives WR0 then WR1.
//  PRE issues in cycle C+T_RTP+1 (read/fetch) or C+T_CWL+T_BURST+T_WR+1 (write), where C = CAS0 cycle.
//  done is asserted in the PRE cycle; req_ready rises the following cycle.
//  A new request may be accepted in that cycle.
//  Waiting states output cmd_valid=0, cmd_code=NOP; cmd_* fields hold the latched request until the next acceptance.
//  Per-bank tracker: on PRE, the counter for {bg,bank} loads T_RP-1 and decrements each cycle to 0 (saturating).
//    The earliest next ACT0 to that bank is therefore PRE cycle + T_RP. Other banks are unaffected.
//  The main delay counter is a down-counter loaded on ACT0 and CAS0.
//    Transitions happen when it reaches 0; no wrap-around is permitted.
//  Only one request is in flight; there is no reordering and the queue order is preserved.
//  Reset asserted mid-request: next cycle is IDLE with NOP. No PRE or done is emitted for the aborted request.
//  req_valid held high across reset is not accepted until the first cycle with rst_n=1 and req_ready=1.
// TESTING
//  1 Read op0 addr bank2 bg3 accepted at cyc0 -> ACT0@1 ACT1@2 RD0@40 RD1@41 PRE+done@59 req_ready@60.
//  2 Write op1 accepted at cyc0 -> ACT0@1 WR0@40 WR1@41 PRE+done@117, fields correct.
//  3 Two reads to same bg/bank, second presented at 60 -> second ACT0 held until 98 (59+T_RP).
//  4 Two reads to different banks -> second ACT0@61, no tRP stall.
//  5 op=3 or addr[6]=1 -> err pulse 1 cycle after accept, no cmd_valid, req_ready stays 1.
//  6 rst_n low at cyc30 of a write -> NOP from cyc31, no done; bank ready, ACT0 at 1st cycle after re-accept.

Source files
------------

// File: rtl/msd_cmd_sequencer.sv
// DDR5 closed-page command sequencer: one request at a time, ACT -> CAS -> PRE,
// with per-bank precharge recovery tracking across all 32 banks.
module msd_cmd_sequencer #(
  parameter int T_RP    = 39,
  parameter int T_RCD   = 39,
  parameter int T_RTP   = 18,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8,
  parameter int T_WR    = 30,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_ch,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done,
  output logic        err
);

  // state      | meaning
  // S_IDLE     | ready for a request
  // S_CHK      | wait for target bank tRP; issues ACT0 in the cycle the bank is ready
  // S_ACT1     | second activate slot
  // S_WAIT_RCD | counting down to the CAS slot
  // S_CAS0     | RD0 / WR0
  // S_CAS1     | RD1 / WR1
  // S_WAIT_PRE | counting down read-to-precharge or write recovery
  // S_PRE      | precharge, request retired
  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE
  } state_t;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT0 = 3'd1, C_ACT1 = 3'd2, C_RD0 = 3'd3,
                         C_RD1 = 3'd4, C_WR0 = 3'd5, C_WR1 = 3'd6, C_PRE = 3'd7;

  localparam int RP_W = (T_RP > 1) ? $clog2(T_RP) : 1;

  // Counter is loaded in the issuing slot and the second slot of the pair also
  // elapses, hence the -2 against the full command-to-command distance.
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_CWL + T_BURST + T_WR - 1);
  localparam logic [RP_W-1:0]  RP_LD  = RP_W'(T_RP - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_ld_val;
  logic               lat_wr;
  logic [RP_W-1:0]    rp_cnt [32];
  logic [4:0]         bank_idx;
  logic               bank_ready;
  logic               accept;
  logic               illegal;
  logic               unused_addr;

  assign unused_addr = ^{req_addr[35:34], req_addr[1:0]};

  assign req_ready  = rst_n & (state == S_IDLE);
  assign accept     = req_valid & req_ready;
  assign illegal    = (req_op == 2'd3) | req_addr[6];
  assign bank_idx   = {cmd_bg, cmd_bank};
  assign bank_ready = (rp_cnt[bank_idx] == '0);
  assign cmd_valid  = (cmd_code != C_NOP);
  assign done       = (state == S_PRE);

  always_comb begin
    state_nxt  = state;
    cmd_code   = C_NOP;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    case (state)
      S_IDLE: if (accept && !illegal) state_nxt = S_CHK;
      S_CHK: begin
        if (bank_ready) begin
          cmd_code   = C_ACT0;
          cnt_load   = 1'b1;
          cnt_ld_val = RCD_LD;
          state_nxt  = S_ACT1;
        end
      end
      S_ACT1: begin
        cmd_code  = C_ACT1;
        state_nxt = S_WAIT_RCD;
      end
      S_WAIT_RCD: if (cnt == '0) state_nxt = S_CAS0;
      S_CAS0: begin
        cmd_code   = lat_wr ? C_WR0 : C_RD0;
        cnt_load   = 1'b1;
        cnt_ld_val = lat_wr ? WR_LD : RD_LD;
        state_nxt  = S_CAS1;
      end
      S_CAS1: begin
        cmd_code  = lat_wr ? C_WR1 : C_RD1;
        state_nxt = S_WAIT_PRE;
      end
      S_WAIT_PRE: if (cnt == '0) state_nxt = S_PRE;
      S_PRE: begin
        cmd_code  = C_PRE;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_wr   <= 1'b0;
      cmd_ch   <= 1'b0;
      cmd_bg   <= '0;
      cmd_bank <= '0;
      cmd_row  <= '0;
      cmd_col  <= '0;
      err      <= 1'b0;
      for (int i = 0; i < 32; i++) rp_cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_load)        cnt <= cnt_ld_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
      err <= accept & illegal;
      if (accept) begin
        lat_wr   <= (req_op == 2'd1);
        cmd_ch   <= req_addr[6];
        cmd_bg   <= req_addr[9:7];
        cmd_bank <= req_addr[11:10];
        cmd_row  <= req_addr[33:18];
        cmd_col  <= {req_addr[17:12], req_addr[5:2]};
      end
      // Saturating per-bank precharge recovery; only the precharged bank reloads.
      for (int i = 0; i < 32; i++) begin
        if (state == S_PRE && bank_idx == 5'(i)) rp_cnt[i] <= RP_LD;
        else if (rp_cnt[i] != '0)                rp_cnt[i] <= rp_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msd_cmd_sequencer.sv
// Bench for msd_cmd_sequencer: directed timing anchors plus randomized traffic
// compared cycle by cycle against a schedule-based reference model.
module tb_msd_cmd_sequencer;

  localparam int T_RP   = 39;
  localparam int T_RCD  = 39;
  localparam int RD_GAP = 18 + 1;
  localparam int WR_GAP = 38 + 8 + 30 + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic        cmd_ch;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  msd_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ch(cmd_ch), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  bit armed = 1'b0;

  // Reference model: absolute cycle numbers of each scheduled event.
  int          act_c, cas_c, pre_c, err_c, ready_from;
  bit          m_wr;
  logic [35:0] m_addr;
  int          bank_free [32];

  bit accepted_now;
  int acc_cycle;
  int dut_act = -1000, dut_cas = -1000, dut_pre = -1000, dut_err = -1000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    act_c = -100; cas_c = -100; pre_c = -100; err_c = -100;
    ready_from = 0;
    m_wr = 1'b0;
    m_addr = '0;
    for (int i = 0; i < 32; i++) bank_free[i] = 0;
  endtask

  function automatic logic [35:0] mk_addr(input int bg, input int bank, input int ch);
    logic [35:0] a;
    a = {4'($urandom()), $urandom()};
    a[9:7]   = 3'(bg);
    a[11:10] = 2'(bank);
    a[6]     = 1'(ch);
    return a;
  endfunction

  task automatic run_cycle(input logic rv, input logic [1:0] op, input logic [35:0] addr,
                           input logic rn);
    logic       exp_ready;
    logic [2:0] exp_code;
    int         b;
    req_valid = rv;
    req_op    = op;
    req_addr  = addr;
    rst_n     = rn;
    @(negedge clk);
    exp_ready = rn && (t >= ready_from);
    exp_code  = 3'd0;
    if      (t == act_c)     exp_code = 3'd1;
    else if (t == act_c + 1) exp_code = 3'd2;
    else if (t == cas_c)     exp_code = m_wr ? 3'd5 : 3'd3;
    else if (t == cas_c + 1) exp_code = m_wr ? 3'd6 : 3'd4;
    else if (t == pre_c)     exp_code = 3'd7;
    if (armed) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("cmd_valid", 64'(cmd_valid), 64'(exp_code != 3'd0));
      chk("cmd_code",  64'(cmd_code),  64'(exp_code));
      chk("done",      64'(done),      64'(exp_code == 3'd7));
      chk("err",       64'(err),       64'(t == err_c));
      chk("cmd_ch",    64'(cmd_ch),    64'(m_addr[6]));
      chk("cmd_bg",    64'(cmd_bg),    64'(m_addr[9:7]));
      chk("cmd_bank",  64'(cmd_bank),  64'(m_addr[11:10]));
      chk("cmd_row",   64'(cmd_row),   64'(m_addr[33:18]));
      chk("cmd_col",   64'(cmd_col),   64'({m_addr[17:12], m_addr[5:2]}));
    end
    if (cmd_valid && cmd_code == 3'd1) dut_act = t;
    if (cmd_valid && (cmd_code == 3'd3 || cmd_code == 3'd5)) dut_cas = t;
    if (cmd_valid && cmd_code == 3'd7) dut_pre = t;
    if (err) dut_err = t;
    accepted_now = 1'b0;
    if (!rn) begin
      model_reset();
    end else if (rv && exp_ready) begin
      accepted_now = 1'b1;
      acc_cycle    = t;
      m_addr       = addr;
      if (op == 2'd3 || addr[6]) begin
        err_c = t + 1;
      end else begin
        b          = {addr[9:7], addr[11:10]};
        act_c      = (t + 1 > bank_free[b]) ? t + 1 : bank_free[b];
        cas_c      = act_c + T_RCD;
        m_wr       = (op == 2'd1);
        pre_c      = cas_c + (m_wr ? WR_GAP : RD_GAP);
        bank_free[b] = pre_c + T_RP;
        ready_from = pre_c + 1;
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      run_cycle(1'b0, 2'($urandom_range(0, 3)), mk_addr(0, 0, 0), 1'b1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [35:0] addr);
    int n = 0;
    do begin
      run_cycle(1'b1, op, addr, 1'b1);
      n++;
    end while (!accepted_now && n < 400);
    chk("issue_accept", 64'(accepted_now), 64'(1));
  endtask

  initial begin
    int a, b;
    logic [35:0] ad;
    rst_n = 1'b0; req_valid = 1'b1; req_op = 2'd0; req_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    // Reset state with req_valid held high.
    run_cycle(1'b1, 2'd0, mk_addr(1, 1, 0), 1'b0);
    run_cycle(1'b1, 2'd0, mk_addr(1, 1, 0), 1'b0);

    // Read, bank 2 / bg 3.
    issue(2'd0, mk_addr(3, 2, 0)); a = acc_cycle;
    chk("t1_first_accept_immediate", 64'(a), 64'(2));
    idle(65);
    chk("t1_act0", 64'(dut_act - a), 64'(1));
    chk("t1_rd0",  64'(dut_cas - a), 64'(40));
    chk("t1_pre",  64'(dut_pre - a), 64'(59));

    // Write.
    issue(2'd1, mk_addr(1, 0, 0)); a = acc_cycle;
    idle(125);
    chk("t2_act0", 64'(dut_act - a), 64'(1));
    chk("t2_wr0",  64'(dut_cas - a), 64'(40));
    chk("t2_pre",  64'(dut_pre - a), 64'(117));

    // Same bank back to back: tRP stall.
    ad = mk_addr(5, 1, 0);
    issue(2'd0, ad); a = acc_cycle;
    issue(2'd2, mk_addr(5, 1, 0)); b = acc_cycle;
    chk("t3_accept_gap", 64'(b - a), 64'(60));
    idle(120);
    chk("t3_stalled_act0", 64'(dut_act - a), 64'(98));

    // Different banks: no stall.
    issue(2'd0, mk_addr(2, 3, 0)); a = acc_cycle;
    issue(2'd0, mk_addr(6, 0, 0)); b = acc_cycle;
    idle(70);
    chk("t4_accept_gap", 64'(b - a), 64'(60));
    chk("t4_act0", 64'(dut_act - b), 64'(1));

    // Illegal requests.
    issue(2'd3, mk_addr(0, 0, 0)); a = acc_cycle;
    idle(3);
    chk("t5_err_op3", 64'(dut_err - a), 64'(1));
    issue(2'd0, mk_addr(0, 1, 1)); a = acc_cycle;
    issue(2'd3, mk_addr(7, 3, 1)); b = acc_cycle;
    chk("t5_ready_after_illegal", 64'(b - a), 64'(1));
    idle(3);
    chk("t5_err_ch", 64'(dut_err - b), 64'(1));

    // Reset in the middle of a write.
    ad = mk_addr(4, 2, 0);
    issue(2'd1, ad); a = acc_cycle;
    idle(29);
    run_cycle(1'b1, 2'd1, ad, 1'b0);
    idle(130);
    chk("t6_no_pre_after_abort", 64'(dut_pre < a), 64'(1));
    issue(2'd1, ad); b = acc_cycle;
    idle(125);
    chk("t6_act0_after_reset", 64'(dut_act - b), 64'(1));
    chk("t6_pre", 64'(dut_pre - b), 64'(117));

    // Randomized traffic concentrated on few banks to provoke tRP stalls.
    for (int i = 0; i < 4000; i++) begin
      logic       rn, rv;
      logic [1:0] op;
      rn = ($urandom_range(0, 499) != 0);
      rv = ($urandom_range(0, 2) != 0);
      op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_cycle(rv, op,
                mk_addr($urandom_range(0, 1), $urandom_range(0, 1),
                        ($urandom_range(0, 15) == 0) ? 1 : 0),
                rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
